bcd_rtc_core: RTL and testbench
===============================

BCD_RTC_CORE -- requirements
Module: bcd_rtc_core

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000; input clock frequency, sets the 1 Hz prescaler terminal count (CLK_HZ-1).
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 run  input  1  1 = time advances, 0 = time frozen (setting mode active).
REQ-005 load  input  1  one-cycle strobe; copies the load_* values into the time registers.
REQ-006 load_year  input  16  BCD year, 4 digits.
REQ-007 load_month, load_day, load_hour, load_minute, load_sec  input  8 each  BCD, 2 digits.
REQ-008 load_week  input  4  weekday 0..6, 0 = Sunday.
REQ-009 year  output  16  current BCD year.
REQ-010 month, day, hour, minute, sec  output  8 each  current BCD fields.
REQ-011 week  output  4  current weekday 0..6.
REQ-012 tick_1hz  output  1  one-cycle pulse in the cycle the seconds field advances.

Function
REQ-013 All outputs shall be registered; load sampled at edge N shall be visible on the outputs after edge N.
REQ-014 A prescaler shall count 0..CLK_HZ-1 while run=1 and load=0; a second tick shall occur at terminal count, then the prescaler shall wrap to 0.
REQ-015 While run=0 the prescaler and all time fields shall hold, and tick_1hz shall stay 0.
REQ-016 load shall take priority over a coincident tick: the loaded values win, the tick is dropped, the prescaler is cleared to 0, and tick_1hz stays 0.
REQ-017 On a tick, sec shall increment in BCD; 59 shall wrap to 00 and carry to minute.
REQ-018 minute 59 shall wrap to 00 and carry to hour; hour 23 shall wrap to 00 and carry to day.
REQ-019 On a day carry, when day >= month length, day shall become 01 and carry to month; otherwise day increments in BCD.
REQ-020 Month length shall be 31/30 per calendar, and February 29 in leap years, 28 otherwise.
REQ-021 Leap year condition: (year mod 4 = 0 and year mod 100 != 0) or year mod 400 = 0. It shall be evaluated from the BCD digits without binary conversion of the full year.
REQ-022 month 12 shall wrap to 01 and carry to year; year shall increment in 4-digit BCD, and 9999 shall wrap to 0000.
REQ-023 week shall increment on every day carry; 6 shall wrap to 0.
REQ-024 Each BCD digit shall stay within 0..9 after any increment; a loaded non-BCD digit has undefined results, but must not cause lockup.
REQ-025 A carry chain triggered by one tick, including year rollover, shall complete in that same edge.

Reset
REQ-026 When rst=1 at an edge: year=16'h2023, month=8'h01, day=8'h01, hour=minute=sec=8'h00, week=0, prescaler=0, tick_1hz=0.
REQ-027 rst shall override load and run; a reset mid-count shall discard the partial second.

Structure
REQ-028 A shared package shall hold the reset-value constants, the weekday encoding, and the BCD month-length constants (28/29/30/31).
REQ-029 One sub-module, bcd2_wrap_counter, shall be used: a 2-digit BCD counter with inc, a programmable wrap value and restart value, and carry_out. It shall be instantiated for sec, minute, hour, day and month.

Verification
REQ-030 Reset: assert rst for 2 cycles -> outputs read 2023-01-01 00:00:00, week 0, no tick_1hz.
REQ-031 Load 2023-12-31 23:59:59 week 0, run=1, CLK_HZ=10 -> after 10 cycles the outputs read 2024-01-01 00:00:00, week 1, with exactly one tick_1hz pulse.
REQ-032 Leap years:
- 2024-02-28 23:59:59 + 1 s -> 2024-02-29
- 2023-02-28 23:59:59 + 1 s -> 2023-03-01
- 2100-02-28 23:59:59 + 1 s -> 2100-03-01
- 2000-02-28 23:59:59 + 1 s -> 2000-02-29
REQ-033 Month ends: 2023-04-30 23:59:59 + 1 s -> 2023-05-01; 2023-05-30 23:59:59 + 1 s -> 2023-05-31.
REQ-034 Priority and freeze:
- load asserted in the prescaler terminal cycle -> loaded value held, no tick, next tick CLK_HZ cycles later.
- run=0 for 3*CLK_HZ cycles -> no change.
REQ-035 Wrap: 9999-12-31 23:59:59 + 1 s -> 0000-01-01 00:00:00.

Source files
------------

// File: rtl/bcd_rtc_core_pkg.sv
// Shared constants and BCD calendar helpers for the real-time clock core.
// Reset date, weekday encoding, month lengths, leap-year and 4-digit BCD increment.
package bcd_rtc_core_pkg;

  typedef enum logic [3:0] {
    WD_SUN = 4'd0,
    WD_MON = 4'd1,
    WD_TUE = 4'd2,
    WD_WED = 4'd3,
    WD_THU = 4'd4,
    WD_FRI = 4'd5,
    WD_SAT = 4'd6
  } weekday_e;

  localparam logic [15:0] RST_YEAR   = 16'h2023;
  localparam logic [7:0]  RST_MONTH  = 8'h01;
  localparam logic [7:0]  RST_DAY    = 8'h01;
  localparam logic [7:0]  RST_HOUR   = 8'h00;
  localparam logic [7:0]  RST_MINUTE = 8'h00;
  localparam logic [7:0]  RST_SEC    = 8'h00;
  localparam logic [3:0]  RST_WEEK   = WD_SUN;

  localparam logic [7:0] MLEN_28 = 8'h28;
  localparam logic [7:0] MLEN_29 = 8'h29;
  localparam logic [7:0] MLEN_30 = 8'h30;
  localparam logic [7:0] MLEN_31 = 8'h31;

  localparam logic [7:0] SEC_WRAP   = 8'h59;
  localparam logic [7:0] MIN_WRAP   = 8'h59;
  localparam logic [7:0] HOUR_WRAP  = 8'h23;
  localparam logic [7:0] MONTH_WRAP = 8'h12;

  // 10*T + U is divisible by 4 iff (2*T + U) is, so only T's parity matters.
  function automatic logic bcd2_div4(input logic [7:0] v);
    if (v[4]) return (v[3:0] == 4'd2) || (v[3:0] == 4'd6);
    else      return (v[3:0] == 4'd0) || (v[3:0] == 4'd4) || (v[3:0] == 4'd8);
  endfunction

  function automatic logic is_leap(input logic [15:0] y);
    if (y[7:0] != 8'h00) return bcd2_div4(y[7:0]);
    else                 return bcd2_div4(y[15:8]);
  endfunction

  function automatic logic [7:0] month_len(input logic [7:0] m, input logic leap);
    case (m)
      8'h02:                      return leap ? MLEN_29 : MLEN_28;
      8'h04, 8'h06, 8'h09, 8'h11: return MLEN_30;
      default:                    return MLEN_31;
    endcase
  endfunction

  function automatic logic [15:0] bcd4_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_rtc_core_if.sv
// Control, load and time-readout bundle of the RTC core.
// master drives run/load and reads the time; slave is the core.
interface bcd_rtc_core_if;
  logic        run;
  logic        load;
  logic [15:0] load_year;
  logic [7:0]  load_month;
  logic [7:0]  load_day;
  logic [7:0]  load_hour;
  logic [7:0]  load_minute;
  logic [7:0]  load_sec;
  logic [3:0]  load_week;
  logic [15:0] year;
  logic [7:0]  month;
  logic [7:0]  day;
  logic [7:0]  hour;
  logic [7:0]  minute;
  logic [7:0]  sec;
  logic [3:0]  week;
  logic        tick_1hz;

  modport master (
    output run, load, load_year, load_month, load_day, load_hour, load_minute, load_sec, load_week,
    input  year, month, day, hour, minute, sec, week, tick_1hz
  );

  modport slave (
    input  run, load, load_year, load_month, load_day, load_hour, load_minute, load_sec, load_week,
    output year, month, day, hour, minute, sec, week, tick_1hz
  );
endinterface

// File: rtl/bcd_rtc_core_bcd2_wrap_counter.sv
// Two-digit BCD counter with load, programmable wrap and restart values.
// Registered count; carry_out is combinational so a whole carry chain settles in one edge.
module bcd2_wrap_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rst_val,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       inc,
  input  logic [7:0] wrap_val,
  input  logic [7:0] restart_val,
  output logic [7:0] q,
  output logic       carry_out
);

  // >= rather than == so a loaded out-of-range value still wraps instead of locking up.
  logic       at_wrap;
  logic [7:0] nxt;

  assign at_wrap   = (q >= wrap_val);
  assign carry_out = inc && at_wrap;

  always_comb begin
    nxt = q;
    if (at_wrap)              nxt = restart_val;
    else if (q[3:0] >= 4'd9)  nxt = {q[7:4] + 4'd1, 4'd0};
    else                      nxt = {q[7:4], q[3:0] + 4'd1};
  end

  always_ff @(posedge clk) begin
    if (rst)       q <= rst_val;
    else if (load) q <= load_val;
    else if (inc)  q <= nxt;
  end

endmodule

// File: rtl/bcd_rtc_core.sv
// BCD calendar clock: 1 Hz prescaler plus sec..year carry chain, all outputs registered.
// Load wins over a coincident tick and clears the prescaler; run=0 freezes everything.
module bcd_rtc_core
  import bcd_rtc_core_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic            clk,
  input  logic            rst,
  bcd_rtc_core_if.slave   bus
);

  localparam int             PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]  TC = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic          tick_q;
  logic [15:0]   year_q;
  logic [3:0]    week_q;
  logic [7:0]    sec_q, minute_q, hour_q, day_q, month_q;
  logic          c_sec, c_minute, c_hour, c_day, c_month;
  logic [7:0]    mlen;

  assign tick = bus.run && !bus.load && (presc == TC);
  assign mlen = month_len(month_q, is_leap(year_q));

  bcd2_wrap_counter u_sec (
    .clk(clk), .rst(rst), .rst_val(RST_SEC), .load(bus.load), .load_val(bus.load_sec),
    .inc(tick), .wrap_val(SEC_WRAP), .restart_val(8'h00), .q(sec_q), .carry_out(c_sec)
  );

  bcd2_wrap_counter u_minute (
    .clk(clk), .rst(rst), .rst_val(RST_MINUTE), .load(bus.load), .load_val(bus.load_minute),
    .inc(c_sec), .wrap_val(MIN_WRAP), .restart_val(8'h00), .q(minute_q), .carry_out(c_minute)
  );

  bcd2_wrap_counter u_hour (
    .clk(clk), .rst(rst), .rst_val(RST_HOUR), .load(bus.load), .load_val(bus.load_hour),
    .inc(c_minute), .wrap_val(HOUR_WRAP), .restart_val(8'h00), .q(hour_q), .carry_out(c_hour)
  );

  bcd2_wrap_counter u_day (
    .clk(clk), .rst(rst), .rst_val(RST_DAY), .load(bus.load), .load_val(bus.load_day),
    .inc(c_hour), .wrap_val(mlen), .restart_val(8'h01), .q(day_q), .carry_out(c_day)
  );

  bcd2_wrap_counter u_month (
    .clk(clk), .rst(rst), .rst_val(RST_MONTH), .load(bus.load), .load_val(bus.load_month),
    .inc(c_day), .wrap_val(MONTH_WRAP), .restart_val(8'h01), .q(month_q), .carry_out(c_month)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      presc  <= '0;
      tick_q <= 1'b0;
      year_q <= RST_YEAR;
      week_q <= RST_WEEK;
    end else begin
      tick_q <= tick;
      if (bus.load)     presc <= '0;
      else if (bus.run) presc <= (presc == TC) ? '0 : presc + PW'(1);
      if (bus.load)         year_q <= bus.load_year;
      else if (c_month)     year_q <= bcd4_inc(year_q);
      // The weekday follows every day advance, including month and year rollovers.
      if (bus.load)         week_q <= bus.load_week;
      else if (c_hour)      week_q <= (week_q >= WD_SAT) ? 4'd0 : week_q + 4'd1;
    end
  end

  assign bus.year     = year_q;
  assign bus.month    = month_q;
  assign bus.day      = day_q;
  assign bus.hour     = hour_q;
  assign bus.minute   = minute_q;
  assign bus.sec      = sec_q;
  assign bus.week     = week_q;
  assign bus.tick_1hz = tick_q;

endmodule

// File: tb/tb_bcd_rtc_core.sv
// Directed bench for bcd_rtc_core at CLK_HZ=10: calendar rollover table plus
// hand sequences for reset, load/tick priority, freeze and mid-count reset.
module tb_bcd_rtc_core;

  localparam int HZ = 10;

  typedef struct packed {
    logic [15:0] year;
    logic [7:0]  month;
    logic [7:0]  day;
    logic [7:0]  hour;
    logic [7:0]  minute;
    logic [7:0]  sec;
    logic [3:0]  week;
  } tm_t;

  typedef struct {
    tm_t in;
    tm_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  bcd_rtc_core_if bus ();

  bcd_rtc_core #(.CLK_HZ(HZ)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  function automatic tm_t mk(input logic [15:0] y, input logic [7:0] mo, input logic [7:0] d,
                             input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s,
                             input logic [3:0] w);
    tm_t t;
    t.year = y; t.month = mo; t.day = d; t.hour = h; t.minute = mi; t.sec = s; t.week = w;
    return t;
  endfunction

  function automatic tm_t now();
    return mk(bus.year, bus.month, bus.day, bus.hour, bus.minute, bus.sec, bus.week);
  endfunction

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive_load(input tm_t t);
    bus.load        = 1'b1;
    bus.load_year   = t.year;
    bus.load_month  = t.month;
    bus.load_day    = t.day;
    bus.load_hour   = t.hour;
    bus.load_minute = t.minute;
    bus.load_sec    = t.sec;
    bus.load_week   = t.week;
  endtask

  // Returns at the negedge after the edge that sampled load; prescaler is 0 there.
  task automatic load_time(input tm_t t);
    @(negedge clk);
    drive_load(t);
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic count_ticks(input int n, output int ticks);
    ticks = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.tick_1hz) ticks++;
    end
  endtask

  // Bounded wait: cycles until the next tick, or max+1 if none arrives.
  task automatic cycles_to_tick(input int max, output int cyc);
    cyc = max + 1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (bus.tick_1hz) begin
        cyc = i;
        break;
      end
    end
  endtask

  vec_t vecs[13];
  tm_t  rst_tm;
  tm_t  held;
  int   n;

  initial begin
    vecs[0].in   = mk(16'h2023, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59, 4'd0);
    vecs[0].exp  = mk(16'h2024, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 4'd1);
    vecs[1].in   = mk(16'h2024, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 4'd3);
    vecs[1].exp  = mk(16'h2024, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00, 4'd4);
    vecs[2].in   = mk(16'h2023, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 4'd2);
    vecs[2].exp  = mk(16'h2023, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 4'd3);
    vecs[3].in   = mk(16'h2100, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 4'd0);
    vecs[3].exp  = mk(16'h2100, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 4'd1);
    vecs[4].in   = mk(16'h2000, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 4'd1);
    vecs[4].exp  = mk(16'h2000, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00, 4'd2);
    vecs[5].in   = mk(16'h2023, 8'h04, 8'h30, 8'h23, 8'h59, 8'h59, 4'd0);
    vecs[5].exp  = mk(16'h2023, 8'h05, 8'h01, 8'h00, 8'h00, 8'h00, 4'd1);
    vecs[6].in   = mk(16'h2023, 8'h05, 8'h30, 8'h23, 8'h59, 8'h59, 4'd2);
    vecs[6].exp  = mk(16'h2023, 8'h05, 8'h31, 8'h00, 8'h00, 8'h00, 4'd3);
    vecs[7].in   = mk(16'h9999, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59, 4'd6);
    vecs[7].exp  = mk(16'h0000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 4'd0);
    vecs[8].in   = mk(16'h2023, 8'h06, 8'h15, 8'h12, 8'h34, 8'h09, 4'd4);
    vecs[8].exp  = mk(16'h2023, 8'h06, 8'h15, 8'h12, 8'h34, 8'h10, 4'd4);
    vecs[9].in   = mk(16'h2023, 8'h06, 8'h15, 8'h09, 8'h59, 8'h59, 4'd4);
    vecs[9].exp  = mk(16'h2023, 8'h06, 8'h15, 8'h10, 8'h00, 8'h00, 4'd4);
    vecs[10].in  = mk(16'h2024, 8'h02, 8'h29, 8'h23, 8'h59, 8'h59, 4'd4);
    vecs[10].exp = mk(16'h2024, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 4'd5);
    vecs[11].in  = mk(16'h2023, 8'h11, 8'h30, 8'h23, 8'h59, 8'h59, 4'd4);
    vecs[11].exp = mk(16'h2023, 8'h12, 8'h01, 8'h00, 8'h00, 8'h00, 4'd5);
    vecs[12].in  = mk(16'h1999, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59, 4'd5);
    vecs[12].exp = mk(16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 4'd6);
    rst_tm       = mk(16'h2023, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 4'd0);

    // Reset held 2 cycles while load and run are also asserted: reset must win.
    rst = 1'b1;
    bus.run = 1'b1;
    drive_load(mk(16'h1234, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 4'd3));
    count_ticks(2, n);
    check("reset_time", now(), rst_tm);
    check("reset_tick_count", 68'(n), 68'd0);
    rst = 1'b0;
    bus.load = 1'b0;
    bus.run  = 1'b0;
    @(negedge clk);
    check("reset_tick_low", 68'(bus.tick_1hz), 68'd0);

    // Rollover table: one second after each load, exactly one tick.
    bus.run = 1'b1;
    foreach (vecs[i]) begin
      load_time(vecs[i].in);
      check($sformatf("vec%0d_loaded", i), now(), vecs[i].in);
      count_ticks(HZ, n);
      check($sformatf("vec%0d_time", i), now(), vecs[i].exp);
      check($sformatf("vec%0d_ticks", i), 68'(n), 68'd1);
    end

    // Load coinciding with the prescaler terminal count.
    load_time(mk(16'h2023, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 4'd0));
    count_ticks(HZ - 1, n);
    check("prio_pre_ticks", 68'(n), 68'd0);
    held = mk(16'h2023, 8'h07, 8'h04, 8'h10, 8'h20, 8'h30, 4'd2);
    drive_load(held);
    @(negedge clk);
    bus.load = 1'b0;
    check("prio_tick_dropped", 68'(bus.tick_1hz), 68'd0);
    check("prio_loaded_wins", now(), held);
    cycles_to_tick(3 * HZ, n);
    check("prio_next_tick_delay", 68'(n), 68'(HZ));
    held.sec = 8'h31;
    check("prio_after_tick", now(), held);

    // Freeze mid-second: time and prescaler hold, tick resumes where it left off.
    held = mk(16'h2023, 8'h03, 8'h14, 8'h15, 8'h09, 8'h26, 4'd2);
    load_time(held);
    count_ticks(4, n);
    bus.run = 1'b0;
    count_ticks(3 * HZ, n);
    check("freeze_ticks", 68'(n), 68'd0);
    check("freeze_time", now(), held);
    bus.run = 1'b1;
    cycles_to_tick(3 * HZ, n);
    check("freeze_resume_delay", 68'(n), 68'(HZ - 4));
    held.sec = 8'h27;
    check("freeze_resume_time", now(), held);

    // Reset mid-count discards the partial second.
    load_time(mk(16'h2030, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 4'd1));
    count_ticks(5, n);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_time", now(), rst_tm);
    cycles_to_tick(3 * HZ, n);
    check("midrst_tick_delay", 68'(n), 68'(HZ));
    check("midrst_after_tick", now(), mk(16'h2023, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 4'd0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
